pool2x2_stream: RTL and testbench

Streaming 2x2, stride-2 pooling engine for multi-bit feature-map pixels. It sits between the STFT/convolution output and the next network layer. It consumes one raster-ordered pixel per valid cycle and emits one pooled pixel per 2x2 window, so the output frame is (W/2)x(H/2). Max or average reduction is selected per frame, and the frame dimensions, pixel width and counter widths are set by parameters.

---
 rtl/pool2x2_stream_pkg.sv | 15 +
 rtl/pool2x2_stream_line_buf.sv | 22 ++
 rtl/pool2x2_stream.sv | 104 ++++++++++
 tb/tb_pool2x2_stream.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pool2x2_stream_pkg.sv
// Shared constants for the 2x2 stride-2 pooling engine.
package pool2x2_stream_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // Four-pixel sum divided by four
  localparam int unsigned AVG_SHIFT = 2;

  // Line-buffer word holds a horizontal pair sum, so it needs one extra bit
  function automatic int unsigned lbWidth(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/pool2x2_stream_line_buf.sv
// One-line buffer of horizontal reductions: synchronous write, combinational read.
module pool_line_buf #(
  parameter int unsigned Depth = 15,
  parameter int unsigned Width = 9,
  parameter int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             iCLK,
  input  logic             iWE,
  input  logic [AW-1:0]    iADDR,
  input  logic [Width-1:0] iWDATA,
  output logic [Width-1:0] oRDATA
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge iCLK) begin
    if (iWE) mem[iADDR] <= iWDATA;
  end

  assign oRDATA = mem[iADDR];

endmodule

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 max/average pooling over a raster-ordered pixel stream.
module pool2x2_stream
  import pool2x2_stream_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned W  = 30,
  parameter int unsigned H  = 30,
  parameter int unsigned CW = 5,
  parameter int unsigned RW = 5
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iCLR,
  input  logic          iVALID,
  input  logic [DW-1:0] iDATA,
  input  logic          iMODE,
  output logic          oVALID,
  output logic [DW-1:0] oDATA,
  output logic          oLAST
);

  localparam int unsigned LW    = lbWidth(DW);
  localparam int unsigned Depth = W / 2;
  localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CW-1:0] ColLast = CW'(W - 1);
  localparam logic [RW-1:0] RowLast = RW'(H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] pair;
  logic          mode;

  logic          accept, colOdd, rowOdd, colEnd, rowEnd, lbWe;
  logic [AW-1:0] lbAddr;
  logic [LW-1:0] hred, lbRd;
  logic [DW+1:0] sum;
  logic [DW-1:0] vred;

  always_comb begin
    accept = iVALID & ~iCLR;
    colOdd = col[0];
    rowOdd = row[0];
    colEnd = (col == ColLast);
    rowEnd = (row == RowLast);
    lbAddr = AW'(col >> 1);
    lbWe   = accept & colOdd & ~rowOdd;
    // mode is already latched for this frame whenever col is odd
    if (mode == MODE_AVG) hred = {1'b0, pair} + {1'b0, iDATA};
    else                  hred = (pair > iDATA) ? LW'(pair) : LW'(iDATA);
    sum = {1'b0, lbRd} + {1'b0, hred};
    if (mode == MODE_AVG) vred = DW'(sum >> AVG_SHIFT);
    else                  vred = (lbRd > hred) ? lbRd[DW-1:0] : hred[DW-1:0];
  end

  pool_line_buf #(
    .Depth (Depth),
    .Width (LW),
    .AW    (AW)
  ) uLineBuf (
    .iCLK   (iCLK),
    .iWE    (lbWe),
    .iADDR  (lbAddr),
    .iWDATA (hred),
    .oRDATA (lbRd)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      col    <= '0;
      row    <= '0;
      pair   <= '0;
      mode   <= MODE_MAX;
      oVALID <= 1'b0;
      oLAST  <= 1'b0;
      oDATA  <= '0;
    end else if (iCLR) begin
      col    <= '0;
      row    <= '0;
      pair   <= '0;
      oVALID <= 1'b0;
      oLAST  <= 1'b0;
      oDATA  <= '0;
    end else begin
      oVALID <= 1'b0;
      oLAST  <= 1'b0;
      if (accept) begin
        if (col == '0 && row == '0) mode <= iMODE;
        if (!colOdd) pair <= iDATA;
        if (colEnd) begin
          col <= '0;
          row <= rowEnd ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (colOdd && rowOdd) begin
          oDATA  <= vred;
          oVALID <= 1'b1;
          oLAST  <= colEnd && rowEnd;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench: 4x4 frames against hand-computed windows, plus one 30x30 max frame.
module tb_pool2x2_stream;

  logic       iCLK = 1'b0;
  logic       iRSTn = 1'b0;
  logic       iCLR = 1'b0;
  logic       iVALID = 1'b0;
  logic [7:0] iDATA = '0;
  logic       iMODE = 1'b0;
  logic       oVALID, oLAST;
  logic [7:0] oDATA;

  logic       bVALID = 1'b0;
  logic [7:0] bDATA = '0;
  logic       bOVALID, bOLAST;
  logic [7:0] bODATA;

  int nAsserts = 0;
  int nFails = 0;
  logic [7:0] held = '0;

  logic [7:0] ramp [16];
  logic [7:0] avgPx [16];
  logic [7:0] expMax [4];
  logic [7:0] expAvg [4];
  logic [7:0] expAvgRamp [4];

  always #5 iCLK = ~iCLK;

  pool2x2_stream #(.DW(8), .W(4), .H(4), .CW(2), .RW(2)) dut (
    .iCLK   (iCLK),
    .iRSTn  (iRSTn),
    .iCLR   (iCLR),
    .iVALID (iVALID),
    .iDATA  (iDATA),
    .iMODE  (iMODE),
    .oVALID (oVALID),
    .oDATA  (oDATA),
    .oLAST  (oLAST)
  );

  pool2x2_stream #(.DW(8), .W(30), .H(30), .CW(5), .RW(5)) dutBig (
    .iCLK   (iCLK),
    .iRSTn  (iRSTn),
    .iCLR   (iCLR),
    .iVALID (bVALID),
    .iDATA  (bDATA),
    .iMODE  (iMODE),
    .oVALID (bOVALID),
    .oDATA  (bODATA),
    .oLAST  (bOLAST)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drivePix(input logic [7:0] d, input logic m);
    iVALID = 1'b1;
    iDATA  = d;
    iMODE  = m;
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
  endtask

  // Drives one 4x4 frame; checks pulse timing, data, oLAST and hold every cycle.
  task automatic runFrame(input logic [7:0] px [16], input logic m0, input logic m1,
                          input int sw, input logic [7:0] ex [4], input bit bubble,
                          input string tag);
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      if (bubble) begin
        int gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
          iVALID = 1'b0;
          @(posedge iCLK);
          #1;
          check({tag, " gap valid"}, 32'(oVALID), 32'd0);
          check({tag, " gap hold"}, 32'(oDATA), 32'(held));
        end
      end
      iVALID = 1'b1;
      iDATA  = px[i];
      iMODE  = (i >= sw) ? m1 : m0;
      @(posedge iCLK);
      #1;
      if ((i / 4) % 2 == 1 && (i % 4) % 2 == 1) begin
        check({tag, " valid"}, 32'(oVALID), 32'd1);
        check({tag, " data"}, 32'(oDATA), 32'(ex[k]));
        check({tag, " last"}, 32'(oLAST), (i == 15) ? 32'd1 : 32'd0);
        held = ex[k];
        k++;
      end else begin
        check({tag, " idle valid"}, 32'(oVALID), 32'd0);
        check({tag, " idle last"}, 32'(oLAST), 32'd0);
        check({tag, " idle hold"}, 32'(oDATA), 32'(held));
      end
    end
    iVALID = 1'b0;
  endtask

  function automatic logic [7:0] bigPix(input int r, input int c);
    return 8'((r * 30 + c) & 255);
  endfunction

  initial begin
    int pulses, lasts;
    logic [7:0] a, b, c, d, m;
    for (int i = 0; i < 16; i++) ramp[i] = 8'(i);
    avgPx = '{8'd1, 8'd2, 8'd9, 8'd9, 8'd3, 8'd5, 8'd9, 8'd9,
              8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd1};
    expMax     = '{8'd5, 8'd7, 8'd13, 8'd15};
    expAvg     = '{8'd2, 8'd9, 8'd255, 8'd0};
    expAvgRamp = '{8'd2, 8'd4, 8'd10, 8'd12};

    #12;
    check("reset oVALID", 32'(oVALID), 32'd0);
    check("reset oLAST", 32'(oLAST), 32'd0);
    check("reset oDATA", 32'(oDATA), 32'd0);
    iRSTn = 1'b1;
    @(posedge iCLK);
    #1;

    runFrame(ramp, 1'b0, 1'b0, 0, expMax, 1'b0, "max1");
    runFrame(ramp, 1'b0, 1'b0, 0, expMax, 1'b0, "max2");
    runFrame(avgPx, 1'b1, 1'b1, 0, expAvg, 1'b0, "avg");
    runFrame(ramp, 1'b0, 1'b0, 0, expMax, 1'b1, "bubble");

    // Clear with a coincident pixel after six accepted pixels
    for (int i = 0; i < 6; i++) drivePix(ramp[i], 1'b0);
    check("pre-clr data", 32'(oDATA), 32'd5);
    iCLR   = 1'b1;
    iVALID = 1'b1;
    iDATA  = 8'd99;
    @(posedge iCLK);
    #1;
    iCLR   = 1'b0;
    iVALID = 1'b0;
    check("clr valid", 32'(oVALID), 32'd0);
    check("clr data", 32'(oDATA), 32'd0);
    check("clr last", 32'(oLAST), 32'd0);
    held = '0;
    runFrame(ramp, 1'b0, 1'b0, 0, expMax, 1'b0, "postclr");

    runFrame(ramp, 1'b0, 1'b1, 6, expMax, 1'b0, "modechg");
    runFrame(ramp, 1'b1, 1'b1, 0, expAvgRamp, 1'b0, "avgramp");

    // Asynchronous reset between edges after nine accepted pixels
    for (int i = 0; i < 9; i++) drivePix(ramp[i], 1'b0);
    check("pre-rst data", 32'(oDATA), 32'd7);
    #2;
    iRSTn = 1'b0;
    #1;
    check("async rst data", 32'(oDATA), 32'd0);
    check("async rst valid", 32'(oVALID), 32'd0);
    #2;
    iRSTn = 1'b1;
    @(posedge iCLK);
    #1;
    held = '0;
    runFrame(ramp, 1'b0, 1'b0, 0, expMax, 1'b0, "postrst");

    // Full-size 30x30 max frame
    pulses = 0;
    lasts = 0;
    for (int r = 0; r < 30; r++) begin
      for (int cc = 0; cc < 30; cc++) begin
        bVALID = 1'b1;
        bDATA  = bigPix(r, cc);
        iMODE  = 1'b0;
        @(posedge iCLK);
        #1;
        if (bOVALID) pulses++;
        if (bOLAST) lasts++;
        if (r % 2 == 1 && cc % 2 == 1) begin
          a = bigPix(r - 1, cc - 1);
          b = bigPix(r - 1, cc);
          c = bigPix(r, cc - 1);
          d = bigPix(r, cc);
          m = a;
          if (b > m) m = b;
          if (c > m) m = c;
          if (d > m) m = d;
          check("big valid", 32'(bOVALID), 32'd1);
          check("big data", 32'(bODATA), 32'(m));
        end else begin
          check("big idle", 32'(bOVALID), 32'd0);
        end
      end
    end
    bVALID = 1'b0;
    check("big count", 32'(pulses), 32'd225);
    check("big last count", 32'(lasts), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
